// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: icache and dcache share one RAM port through an IDLE/IGRANT/DGRANT FSM.
// Define MEM_ARBITER_RR_EN to alternate priority on contention; otherwise dcache has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'b10;

    state_t state, state_next;
    logic   dreq;
    logic   access;
    logic   d_wins;

    assign dreq   = dREN | dWEN;
    assign access = (ramstate == RAM_ACCESS);
    assign iload  = ramload;
    assign dload  = ramload;

`ifdef MEM_ARBITER_RR_EN
    // Set when the most recent grant went to the dcache; reset favours the dcache.
    logic last_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            last_d <= 1'b0;
        else if (state == IDLE && state_next != IDLE)
            last_d <= (state_next == DGRANT);
    end

    assign d_wins = dreq && !(iREN && last_d);
`else
    assign d_wins = dreq;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (state)
            IDLE: begin
                if (d_wins)
                    state_next = DGRANT;
                else if (iREN)
                    state_next = IGRANT;
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    state_next = IDLE;
                end else if (access) begin
                    iwait      = 1'b0;
                    state_next = IDLE;
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!dreq) begin
                    state_next = IDLE;
                end else if (access) begin
                    dwait      = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expected grant order depends on MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              iREN, dREN, dWEN;
    logic [ADDR_W-1:0] iaddr, daddr;
    logic [WORD_W-1:0] dstore;
    logic              iwait, dwait;
    logic [WORD_W-1:0] iload, dload;
    logic              ramREN, ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

    mem_arbiter #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // Advance to 2 time units after the next rising edge; inputs change here, checks follow after #2.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 0;
        tick();
        tick();
        nRST = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 0;
        #3;
        n_checks++;
        if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0011", {ramREN, ramWEN, iwait, dwait});
        end
        n_checks++;
        if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %h store %h expected 0 0", ramaddr, ramstore);
        end
        tick();
        nRST = 1;
        tick();
    endtask

    task automatic test_dread();
        do_reset();
        dREN = 1; daddr = 32'h40; ramstate = BUSY; ramload = 32'hDEADBEEF;
        #2;
        n_checks++;
        if (ramREN !== 1'b0 || dwait !== 1'b1) begin
            n_fail++;
            $display("FAIL dread_idle: got ren %b dwait %b expected 0 1", ramREN, dwait);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            #2;
            n_checks++;
            if ({ramREN, ramWEN, dwait, iwait} !== 4'b1011 || ramaddr !== 32'h40) begin
                n_fail++;
                $display("FAIL dread_busy%0d: got %b addr %h expected 1011 addr 40", c,
                         {ramREN, ramWEN, dwait, iwait}, ramaddr);
            end
        end
        ramstate = ACCESS;
        #2;
        n_checks++;
        if (dwait !== 1'b0 || dload !== 32'hDEADBEEF || iload !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL dread_access: got dwait %b dload %h iload %h expected 0 deadbeef deadbeef",
                     dwait, dload, iload);
        end
        tick();
        dREN = 0; ramstate = FREE;
        #2;
        n_checks++;
        if ({ramREN, ramWEN, dwait} !== 3'b001 || ramaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL dread_after: got %b addr %h expected 001 addr 0", {ramREN, ramWEN, dwait}, ramaddr);
        end
    endtask

    task automatic test_both_same_cycle();
        do_reset();
        iREN = 1; iaddr = 32'h200; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678; ramstate = FREE;
        tick();
        #2;
        n_checks++;
        if ({ramWEN, ramREN, iwait, dwait} !== 4'b1011 || ramstore !== 32'h12345678 || ramaddr !== 32'h80) begin
            n_fail++;
            $display("FAIL both_dgrant: got %b store %h addr %h expected 1011 12345678 80",
                     {ramWEN, ramREN, iwait, dwait}, ramstore, ramaddr);
        end
        ramstate = ACCESS;
        #2;
        n_checks++;
        if (dwait !== 1'b0 || iwait !== 1'b1) begin
            n_fail++;
            $display("FAIL both_daccess: got dwait %b iwait %b expected 0 1", dwait, iwait);
        end
        tick();
        dWEN = 0; ramstate = FREE;
        #2;
        n_checks++;
        if ({ramREN, ramWEN, iwait} !== 3'b001) begin
            n_fail++;
            $display("FAIL both_idle: got %b expected 001", {ramREN, ramWEN, iwait});
        end
        tick();
        #2;
        n_checks++;
        if ({ramREN, ramWEN, dwait, iwait} !== 4'b1011 || ramaddr !== 32'h200 || ramstore !== 32'h0) begin
            n_fail++;
            $display("FAIL both_igrant: got %b addr %h store %h expected 1011 200 0",
                     {ramREN, ramWEN, dwait, iwait}, ramaddr, ramstore);
        end
        ramstate = ACCESS;
        #2;
        n_checks++;
        if (iwait !== 1'b0 || dwait !== 1'b1) begin
            n_fail++;
            $display("FAIL both_iaccess: got iwait %b dwait %b expected 0 1", iwait, dwait);
        end
        tick();
        iREN = 0; ramstate = FREE;
    endtask

    task automatic test_priority();
        logic [ADDR_W-1:0] exp_addr [4];
`ifdef MEM_ARBITER_RR_EN
        exp_addr = '{32'h100, 32'h200, 32'h100, 32'h200};
`else
        exp_addr = '{32'h100, 32'h100, 32'h100, 32'h100};
`endif
        do_reset();
        iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h100; ramstate = ACCESS;
        for (int g = 0; g < 4; g++) begin
            tick();
            #2;
            n_checks++;
            if (ramREN !== 1'b1 || ramaddr !== exp_addr[g]) begin
                n_fail++;
                $display("FAIL prio_grant%0d: got ren %b addr %h expected 1 %h", g, ramREN, ramaddr, exp_addr[g]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        dWEN = 1; daddr = 32'h44; dstore = 32'hA5A5A5A5; ramstate = BUSY;
        tick();
        #1;
        n_checks++;
        if (ramWEN !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got ramWEN %b expected 1", ramWEN);
        end
        nRST = 0;
        #1;
        n_checks++;
        if ({ramWEN, ramREN, dwait, iwait} !== 4'b0011 || ramaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b addr %h expected 0011 addr 0", {ramWEN, ramREN, dwait, iwait}, ramaddr);
        end
        dWEN = 0;
        tick();
        nRST = 1;
        tick();
        #2;
        n_checks++;
        if ({ramWEN, ramREN, dwait} !== 3'b001) begin
            n_fail++;
            $display("FAIL rstmid_idle: got %b expected 001", {ramWEN, ramREN, dwait});
        end
    endtask

    task automatic test_drop_and_error();
        int saw_iwait_low = 0;
        do_reset();
        iREN = 1; iaddr = 32'h300; ramstate = BUSY;
        tick();
        #2;
        if (iwait === 1'b0) saw_iwait_low++;
        n_checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin
            n_fail++;
            $display("FAIL drop_igrant: got ren %b addr %h expected 1 300", ramREN, ramaddr);
        end
        iREN = 0;
        #1;
        if (iwait === 1'b0) saw_iwait_low++;
        tick();
        #2;
        if (iwait === 1'b0) saw_iwait_low++;
        n_checks++;
        if (ramREN !== 1'b0 || ramaddr !== 32'h0 || saw_iwait_low != 0) begin
            n_fail++;
            $display("FAIL drop_idle: got ren %b addr %h iwait-low count %0d expected 0 0 0",
                     ramREN, ramaddr, saw_iwait_low);
        end
        dREN = 1; daddr = 32'h500; ramstate = ERROR;
        tick();
        for (int c = 0; c < 3; c++) begin
            #2;
            n_checks++;
            if ({ramREN, dwait} !== 2'b11 || ramaddr !== 32'h500) begin
                n_fail++;
                $display("FAIL err_hold%0d: got ren/dwait %b addr %h expected 11 500", c, {ramREN, dwait}, ramaddr);
            end
            tick();
        end
        ramstate = ACCESS;
        #2;
        n_checks++;
        if (dwait !== 1'b0) begin
            n_fail++;
            $display("FAIL err_access: got dwait %b expected 0", dwait);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        nRST = 1;
        test_reset();
        test_dread();
        test_both_same_cycle();
        test_priority();
        test_reset_mid_grant();
        test_drop_and_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
